sys_array_feeder: RTL and testbench
===================================

Name: sys_array_feeder

Overview:
Initiator side of the 2x2 floating-point systolic multiplier.
- Accepts one A/B matrix pair over a valid/ready handshake.
- Streams A rows and B columns into the array with diagonal skew, asserting load_in for the feed window.
- Waits for the array's done, captures the four results, and presents C downstream over valid/ready.
- Sits between the matrix buffer/controller and the systolic array instance.

Parameters:
DATA_W, 32, IEEE-754 single-precision word width.
TIMEOUT_CYCLES, 256, maximum cycles in WAIT before abort (legal range 4..65535).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-low (0 = reset).
in_valid  in  1  A/B pair valid.
in_ready  out  1  feeder can accept a pair.
a_mat  in  4*DATA_W  {a11,a10,a01,a00}, a00 in LSBs.
b_mat  in  4*DATA_W  {b11,b10,b01,b00}, b00 in LSBs.
load_in  out  1  to array; high during the feed window.
row_in_row0, row_in_row1  out  DATA_W  A row streams to the array.
col_in_col0, col_in_col1  out  DATA_W  B column streams to the array.
arr_done  in  1  array done pulse.
result_row00, result_row01, result_row10, result_row11  in  DATA_W  array results.
out_valid  out  1  C matrix valid.
out_ready  in  1  downstream accepts C.
c_mat  out  4*DATA_W  {c11,c10,c01,c00}.
busy  out  1  state != IDLE.
timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (rst=0 at posedge):
  - Outputs: all outputs 0, including in_ready, stream buses, load_in, c_mat and timeout_err.
  - State: IDLE, counters cleared.
  - Mid-operation: reset aborts immediately; no partial output, out_valid drops next edge.
- All outputs are registered. in_ready=1 exactly when in IDLE, so it rises the first cycle after reset release.
- FSM states:
  - IDLE: on in_valid&&in_ready, latch a_mat/b_mat, clear timeout_err, go to FEED with k=0.
  - FEED: 3 cycles, k=0,1,2. Unused slots drive 32'h0 (+0.0). load_in=1 for all three cycles.
    - k=0: row0=a00, row1=0, col0=b00, col1=0.
    - k=1: row0=a01, row1=a10, col0=b10, col1=b01.
    - k=2: row0=0, row1=a11, col0=0, col1=b11.
    - After k=2, go to WAIT.
  - WAIT: load_in=0, all stream buses 0, wait counter increments each cycle.
    - On arr_done=1, capture result_row00..11 into c_mat and go to OUT.
    - If the counter reaches TIMEOUT_CYCLES with no arr_done: set timeout_err=1, c_mat=0, go to IDLE (no out_valid).
  - OUT: out_valid=1; c_mat held stable until out_ready=1, then go to IDLE.
- Boundary conditions:
  - arr_done outside WAIT is ignored.
  - out_valid never drops without out_ready.
  - Back-to-back pairs: minimum period is 3 (FEED) + WAIT + 1 (OUT) + 1 (IDLE) cycles.
  - arr_done in the same cycle the wait counter hits TIMEOUT_CYCLES: done wins, no error.
  - timeout_err stays set until the next accepted input.
- Feeder performs no arithmetic; data passes through bit-exact.

Optional Feature:
SYS_FEEDER_PERF_EN
- Defined: adds output port perf_cycles (16 bits).
  - Counts cycles from input acceptance to the first out_valid cycle.
  - Loaded into a register at entry to OUT, held until the next acceptance, saturates at 16'hFFFF, reset 0.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package sys_array_pkg:
  - FSM state enum (IDLE, FEED, WAIT, OUT).
  - FP_ZERO=32'h0.
  - Matrix element index constants for the flattened buses.
  - Feed length constant 3.
- One natural sub-module: sys_feed_skew. Combinational/registered mux mapping (k, latched A/B) to the four stream buses.
- FSM, timeout and output handshake stay in the top module.

Test Plan:
- Feed skew: A={1,2,3,4} (3F800000,40000000,40400000,40800000), B=identity (3F800000,0,0,3F800000).
  - Stream buses match the k=0..2 table exactly: row0 = 3F800000, 40000000, 0; row1 = 0, 40400000, 40800000; col0 = 3F800000, 0, 0; col1 = 0, 0, 3F800000.
  - load_in high exactly 3 cycles.
- Capture/handshake: with the array model, C=A for the identity case.
  - out_valid asserts and c_mat = {40800000,40400000,40000000,3F800000}.
  - With out_ready held 0 for 5 cycles then 1: c_mat stable, single transfer, in_ready returns next cycle.
- Timeout: arr_done never asserted, TIMEOUT_CYCLES=8.
  - timeout_err=1 after 8 WAIT cycles, no out_valid, in_ready=1.
  - Next accepted pair clears timeout_err.
- Reset mid-FEED: rst=0 at k=1.
  - Next edge: all buses 0, load_in=0, busy=0.
  - After release, a new pair processes normally.
- Spurious done/collision: arr_done pulsed in IDLE and in FEED has no effect.
  - arr_done on the exact timeout cycle yields out_valid and no error.
- Perf (SYS_FEEDER_PERF_EN): done returned 5 cycles into WAIT; perf_cycles equals the measured accept-to-out_valid count (9).

Source files
------------

// File: rtl/sys_array_pkg.sv
// ============================================================================
// Module      : sys_array_pkg
// Description : Shared types and constants for the 2x2 systolic array feeder.
//               Provides the feeder FSM state encoding, the +0.0 fill word,
//               element indices into the flattened 4-element matrix buses,
//               and the number of feed slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // IEEE-754 single-precision +0.0, driven on idle stream slots
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Element positions in {x11,x10,x01,x00}; index = row*2 + col
  localparam int E00 = 0;
  localparam int E01 = 1;
  localparam int E10 = 2;
  localparam int E11 = 3;

  // Number of cycles in the skewed feed window
  localparam int FEED_LEN = 3;

endpackage

`default_nettype wire

// File: rtl/sys_feed_skew.sv
// ============================================================================
// Module      : sys_feed_skew
// Description : Combinational diagonal-skew mux. Maps the feed slot k and the
//               A/B matrices onto the two row streams and two column streams.
//               Row r carries a[r][k-r], column c carries b[k-c][c]; slots
//               outside the diagonal (and all slots when inactive) are +0.0.
// Ports       : active        - feed window is open for this slot
//               k             - feed slot 0..2
//               a_mat, b_mat  - flattened {x11,x10,x01,x00}
//               row0/row1     - A row streams
//               col0/col1     - B column streams
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_feed_skew
  import sys_array_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  active,
  input  logic [1:0]            k,
  input  logic [4*DATA_W-1:0]   a_mat,
  input  logic [4*DATA_W-1:0]   b_mat,
  output logic [DATA_W-1:0]     row0,
  output logic [DATA_W-1:0]     row1,
  output logic [DATA_W-1:0]     col0,
  output logic [DATA_W-1:0]     col1
);

  always_comb begin
    row0 = DATA_W'(FP_ZERO);
    row1 = DATA_W'(FP_ZERO);
    col0 = DATA_W'(FP_ZERO);
    col1 = DATA_W'(FP_ZERO);
    if (active) begin
      case (k)
        2'd0: begin
          row0 = a_mat[E00*DATA_W +: DATA_W];
          col0 = b_mat[E00*DATA_W +: DATA_W];
        end
        2'd1: begin
          row0 = a_mat[E01*DATA_W +: DATA_W];
          row1 = a_mat[E10*DATA_W +: DATA_W];
          col0 = b_mat[E10*DATA_W +: DATA_W];
          col1 = b_mat[E01*DATA_W +: DATA_W];
        end
        2'd2: begin
          row1 = a_mat[E11*DATA_W +: DATA_W];
          col1 = b_mat[E11*DATA_W +: DATA_W];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys_array_feeder.sv
// ============================================================================
// Module      : sys_array_feeder
// Description : Initiator for the 2x2 FP systolic multiplier. Accepts an A/B
//               pair (valid/ready), streams skewed rows/columns for 3 cycles
//               with load_in high, waits for arr_done (with timeout), captures
//               the four results and offers C downstream (valid/ready).
// Ports       : clk, rst (sync, active-low)
//               in_valid/in_ready, a_mat, b_mat      - upstream pair
//               load_in, row_in_row0/1, col_in_col0/1 - array feed
//               arr_done, result_row00..11            - array results
//               out_valid/out_ready, c_mat            - downstream C
//               busy, timeout_err                     - status
//               perf_cycles (SYS_FEEDER_PERF_EN only) - accept-to-out latency
// Options     : SYS_FEEDER_PERF_EN adds the perf_cycles latency counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   a_mat,
  input  logic [4*DATA_W-1:0]   b_mat,
  output logic                  load_in,
  output logic [DATA_W-1:0]     row_in_row0,
  output logic [DATA_W-1:0]     row_in_row1,
  output logic [DATA_W-1:0]     col_in_col0,
  output logic [DATA_W-1:0]     col_in_col1,
  input  logic                  arr_done,
  input  logic [DATA_W-1:0]     result_row00,
  input  logic [DATA_W-1:0]     result_row01,
  input  logic [DATA_W-1:0]     result_row10,
  input  logic [DATA_W-1:0]     result_row11,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DATA_W-1:0]   c_mat,
  output logic                  busy,
`ifdef SYS_FEEDER_PERF_EN
  output logic [15:0]           perf_cycles,
`endif
  output logic                  timeout_err
);

  // Abort fires at the end of the TIMEOUT_CYCLES-th WAIT cycle
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  K_LAST  = 2'(FEED_LEN - 1);

  state_t               r_state;
  logic [1:0]           r_k;
  logic [15:0]          r_wcnt;
  logic [4*DATA_W-1:0]  r_a;
  logic [4*DATA_W-1:0]  r_b;
  logic                 r_in_ready;
  logic                 r_load;
  logic [DATA_W-1:0]    r_row0, r_row1, r_col0, r_col1;
  logic                 r_out_valid;
  logic [4*DATA_W-1:0]  r_c;
  logic                 r_busy;
  logic                 r_terr;

  logic                 w_accept;
  logic                 w_feed_next;
  logic [1:0]           w_k_next;
  logic [4*DATA_W-1:0]  w_a_src, w_b_src;
  logic [DATA_W-1:0]    w_row0, w_row1, w_col0, w_col1;

  assign w_accept = (r_state == IDLE) && r_in_ready && in_valid;

  // Stream registers are loaded with the slot that will be current after
  // this edge; on acceptance the pair is not latched yet, so use the inputs.
  assign w_feed_next = w_accept || ((r_state == FEED) && (r_k != K_LAST));
  assign w_k_next    = w_accept ? 2'd0 : (r_k + 2'd1);
  assign w_a_src     = w_accept ? a_mat : r_a;
  assign w_b_src     = w_accept ? b_mat : r_b;

  sys_feed_skew #(
    .DATA_W (DATA_W)
  ) u_skew (
    .active (w_feed_next),
    .k      (w_k_next),
    .a_mat  (w_a_src),
    .b_mat  (w_b_src),
    .row0   (w_row0),
    .row1   (w_row1),
    .col0   (w_col0),
    .col1   (w_col1)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_k         <= 2'd0;
      r_wcnt      <= 16'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_in_ready  <= 1'b0;
      r_load      <= 1'b0;
      r_row0      <= '0;
      r_row1      <= '0;
      r_col0      <= '0;
      r_col1      <= '0;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_busy      <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_load <= w_feed_next;
      r_row0 <= w_row0;
      r_row1 <= w_row1;
      r_col0 <= w_col0;
      r_col1 <= w_col1;
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a        <= a_mat;
            r_b        <= b_mat;
            r_terr     <= 1'b0;
            r_k        <= 2'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= FEED;
          end
        end
        FEED: begin
          if (r_k == K_LAST) begin
            r_wcnt  <= 16'd0;
            r_state <= WAIT;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        WAIT: begin
          // done takes priority over a coincident timeout
          if (arr_done) begin
            r_c         <= {result_row11, result_row10, result_row01, result_row00};
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end else if (r_wcnt == TO_LAST) begin
            r_terr     <= 1'b1;
            r_c        <= '0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SYS_FEEDER_PERF_EN
  // r_perf_cnt holds the index of the current cycle, the accept cycle being 0
  logic [15:0] r_perf_cnt;
  logic [15:0] r_perf;
  logic [15:0] w_perf_inc;

  assign w_perf_inc = (r_perf_cnt == 16'hFFFF) ? r_perf_cnt : (r_perf_cnt + 16'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_cnt <= 16'd0;
      r_perf     <= 16'd0;
    end else if (w_accept) begin
      r_perf_cnt <= 16'd1;
    end else if ((r_state == FEED) || (r_state == WAIT)) begin
      r_perf_cnt <= w_perf_inc;
      if ((r_state == WAIT) && arr_done) begin
        r_perf <= w_perf_inc;
      end
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign in_ready    = r_in_ready;
  assign load_in     = r_load;
  assign row_in_row0 = r_row0;
  assign row_in_row1 = r_row1;
  assign col_in_col0 = r_col0;
  assign col_in_col1 = r_col1;
  assign out_valid   = r_out_valid;
  assign c_mat       = r_c;
  assign busy        = r_busy;
  assign timeout_err = r_terr;

endmodule

`default_nettype wire

// File: tb/tb_sys_array_feeder.sv
// ============================================================================
// Module      : tb_sys_array_feeder
// Description : Self-checking bench for sys_array_feeder. A transaction-level
//               reference model predicts every registered output each cycle;
//               directed sections pin the model with literal values, then a
//               long randomized section exercises handshakes, reset, spurious
//               done and timeout. Define SYS_FEEDER_PERF_EN to cover
//               perf_cycles as well.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_array_feeder;

  localparam int DW = 32;
  localparam int TO = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   a_mat, b_mat;
  logic           load_in;
  logic [31:0]    row_in_row0, row_in_row1, col_in_col0, col_in_col1;
  logic           arr_done;
  logic [31:0]    result_row00, result_row01, result_row10, result_row11;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   c_mat;
  logic           busy;
  logic           timeout_err;
`ifdef SYS_FEEDER_PERF_EN
  logic [15:0]    perf_cycles;
`endif

  sys_array_feeder #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_mat        (a_mat),
    .b_mat        (b_mat),
    .load_in      (load_in),
    .row_in_row0  (row_in_row0),
    .row_in_row1  (row_in_row1),
    .col_in_col0  (col_in_col0),
    .col_in_col1  (col_in_col1),
    .arr_done     (arr_done),
    .result_row00 (result_row00),
    .result_row01 (result_row01),
    .result_row10 (result_row10),
    .result_row11 (result_row11),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .c_mat        (c_mat),
    .busy         (busy),
`ifdef SYS_FEEDER_PERF_EN
    .perf_cycles  (perf_cycles),
`endif
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_slot: feed slot shown this cycle (-1 none); m_wait: WAIT cycles elapsed
  // (-1 not waiting); m_age: edges since acceptance.
  logic         e_in_ready, e_busy, e_load, e_out_valid, e_terr;
  logic [31:0]  e_row0, e_row1, e_col0, e_col1;
  logic [127:0] e_c, m_a, m_b;
  logic [15:0]  e_perf;
  int           m_slot, m_wait, m_age;

  function automatic logic [31:0] elem(input logic [127:0] m, input int r, input int c);
    return m[(r*2+c)*32 +: 32];
  endfunction

  // Row r at slot s carries a[r][s-r]; column c carries b[s-c][c]
  function automatic logic [31:0] row_word(input logic [127:0] m, input int r, input int s);
    int d = s - r;
    return (d >= 0 && d <= 1) ? elem(m, r, d) : 32'h0;
  endfunction

  function automatic logic [31:0] col_word(input logic [127:0] m, input int c, input int s);
    int d = s - c;
    return (d >= 0 && d <= 1) ? elem(m, d, c) : 32'h0;
  endfunction

  always @(posedge clk) begin
    logic         s_rst, s_iv, s_done, s_ordy, acc;
    logic [127:0] s_a, s_b, s_res;
    s_rst  = rst;
    s_iv   = in_valid;
    s_done = arr_done;
    s_ordy = out_ready;
    s_a    = a_mat;
    s_b    = b_mat;
    s_res  = {result_row11, result_row10, result_row01, result_row00};
    if (!s_rst) begin
      e_in_ready = 0; e_busy = 0; e_load = 0; e_out_valid = 0; e_terr = 0;
      e_c = '0; e_perf = '0; m_slot = -1; m_wait = -1; m_age = 0;
    end else begin
      acc = !e_busy && e_in_ready && s_iv;
      if (e_busy && !acc) m_age++;
      if (!e_busy) begin
        e_in_ready = 1;
        if (acc) begin
          m_a = s_a; m_b = s_b; e_terr = 0; e_busy = 1; e_in_ready = 0;
          m_slot = 0; m_age = 0;
        end
      end else if (m_slot >= 0) begin
        if (m_slot < 2) m_slot++;
        else begin m_slot = -1; m_wait = 0; end
      end else if (m_wait >= 0) begin
        m_wait++;
        if (s_done) begin
          e_c = s_res; e_out_valid = 1; m_wait = -1;
          e_perf = (m_age + 1 > 65535) ? 16'hFFFF : 16'(m_age + 1);
        end else if (m_wait == TO) begin
          e_terr = 1; e_c = '0; e_busy = 0; e_in_ready = 1; m_wait = -1;
        end
      end else if (s_ordy) begin
        e_out_valid = 0; e_busy = 0; e_in_ready = 1;
      end
    end
    e_load = (m_slot >= 0);
    e_row0 = e_load ? row_word(m_a, 0, m_slot) : 32'h0;
    e_row1 = e_load ? row_word(m_a, 1, m_slot) : 32'h0;
    e_col0 = e_load ? col_word(m_b, 0, m_slot) : 32'h0;
    e_col1 = e_load ? col_word(m_b, 1, m_slot) : 32'h0;
    #1;
    chk("in_ready",    in_ready,    e_in_ready);
    chk("busy",        busy,        e_busy);
    chk("load_in",     load_in,     e_load);
    chk("row0",        row_in_row0, e_row0);
    chk("row1",        row_in_row1, e_row1);
    chk("col0",        col_in_col0, e_col0);
    chk("col1",        col_in_col1, e_col1);
    chk("out_valid",   out_valid,   e_out_valid);
    chk("c_mat",       c_mat,       e_c);
    chk("timeout_err", timeout_err, e_terr);
`ifdef SYS_FEEDER_PERF_EN
    chk("perf_cycles", perf_cycles, e_perf);
`endif
  end

  // ---------------- stimulus + literal pins ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic set_res(input logic [127:0] r);
    result_row00 = r[31:0];  result_row01 = r[63:32];
    result_row10 = r[95:64]; result_row11 = r[127:96];
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [31:0]  ex_r0 [3];
    logic [31:0]  ex_r1 [3];
    logic [31:0]  ex_c0 [3];
    logic [31:0]  ex_c1 [3];
    logic [127:0] ident_c, rr;
    int nload, n;
    logic seen_ov;

    ex_r0 = '{32'h3F800000, 32'h40000000, 32'h0};
    ex_r1 = '{32'h0, 32'h40400000, 32'h40800000};
    ex_c0 = '{32'h3F800000, 32'h0, 32'h0};
    ex_c1 = '{32'h0, 32'h0, 32'h3F800000};
    ident_c = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

    rst = 0; in_valid = 0; a_mat = '0; b_mat = '0; arr_done = 0; out_ready = 0;
    set_res('0);
    repeat (3) tick();
    chk("lit_rst_in_ready", in_ready, 0);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_cmat", c_mat, 0);
    chk("lit_rst_terr", timeout_err, 0);
    rst = 1;
    tick();
    chk("lit_in_ready_rise", in_ready, 1);

    // Identity feed: C = A
    a_mat = ident_c;
    b_mat = {32'h3F800000, 32'h0, 32'h0, 32'h3F800000};
    in_valid = 1;
    tick();
    in_valid = 0;
    nload = 0;
    for (int k = 0; k < 3; k++) begin
      chk("lit_skew_row0", row_in_row0, ex_r0[k]);
      chk("lit_skew_row1", row_in_row1, ex_r1[k]);
      chk("lit_skew_col0", col_in_col0, ex_c0[k]);
      chk("lit_skew_col1", col_in_col1, ex_c1[k]);
      nload += int'(load_in);
      tick();
    end
    nload += int'(load_in);
    chk("lit_load_cycles", nload, 3);
    tick();
    arr_done = 1; set_res(ident_c);
    tick();
    arr_done = 0;
    chk("lit_ident_ov", out_valid, 1);
    chk("lit_ident_c", c_mat, ident_c);
    repeat (5) begin
      tick();
      chk("lit_hold_ov", out_valid, 1);
      chk("lit_hold_c", c_mat, ident_c);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("lit_xfer_ov", out_valid, 0);
    chk("lit_xfer_ready", in_ready, 1);

    // Spurious done in IDLE, then in FEED, then timeout
    arr_done = 1;
    tick();
    arr_done = 0;
    chk("lit_idle_done_busy", busy, 0);
    chk("lit_idle_done_ov", out_valid, 0);
    a_mat = rnd128(); b_mat = rnd128(); in_valid = 1;
    tick();
    in_valid = 0; arr_done = 1;
    tick();
    arr_done = 0;
    n = 2; seen_ov = 0;
    while (!in_ready && n < 40) begin
      seen_ov |= out_valid;
      tick();
      n++;
    end
    chk("lit_timeout_latency", n, 12);
    chk("lit_timeout_err", timeout_err, 1);
    chk("lit_timeout_no_ov", seen_ov, 0);

    // Next pair clears the flag; done on the exact timeout cycle wins
    a_mat = rnd128(); in_valid = 1;
    tick();
    in_valid = 0;
    chk("lit_terr_cleared", timeout_err, 0);
    repeat (10) tick();
    rr = rnd128(); set_res(rr); arr_done = 1;
    tick();
    arr_done = 0;
    chk("lit_collide_ov", out_valid, 1);
    chk("lit_collide_terr", timeout_err, 0);
    chk("lit_collide_c", c_mat, rr);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Reset during feed slot 1
    a_mat = rnd128(); b_mat = rnd128(); in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst = 0;
    tick();
    chk("lit_mrst_load", load_in, 0);
    chk("lit_mrst_bus", {row_in_row0, row_in_row1, col_in_col0, col_in_col1}, 0);
    chk("lit_mrst_busy", busy, 0);
    rst = 1;
    tick();
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (3) tick();
    rr = rnd128(); set_res(rr); arr_done = 1;
    tick();
    arr_done = 0;
    chk("lit_after_rst_c", c_mat, rr);
    out_ready = 1;
    tick();
    out_ready = 0;

`ifdef SYS_FEEDER_PERF_EN
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (7) tick();
    arr_done = 1;
    tick();
    arr_done = 0;
    chk("lit_perf_ov", out_valid, 1);
    chk("lit_perf_cycles", perf_cycles, 16'd9);
    out_ready = 1;
    tick();
    out_ready = 0;
`endif

    // Randomized traffic against the model
    repeat (3000) begin
      tick();
      rst       = ($urandom_range(0, 199) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      arr_done  = ($urandom_range(0, 5) == 0);
      a_mat     = rnd128();
      b_mat     = rnd128();
      set_res(rnd128());
    end
    rst = 1; in_valid = 0; arr_done = 0; out_ready = 1;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
